// File: rtl/apb_mux_pkg.sv
// Shared definitions for the APB slave mux: FSM state encoding, default address window, slot constants.
package apb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } mux_state_e;

  localparam int unsigned SLOT_W          = 4;
  localparam logic [15:0] DEFAULT_BASE_HI = 16'h2000;
  localparam logic [3:0]  SLOT_UART       = 4'd0;

endpackage

// File: rtl/apb_slave_mux_if.sv
// Bundles the bridge-side APB bus and the fanned-out slave-side bus of the APB slave mux.
interface apb_slave_mux_if #(
  parameter int unsigned N_SLV  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STRB_W = 2
);
  logic [ADDR_W-1:0]       PADDR;
  logic [DATA_W-1:0]       PWDATA;
  logic [STRB_W-1:0]       PSTRB;
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_W-1:0]       PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [N_SLV-1:0]        SLV_PSEL;
  logic                    SLVENABLE;
  logic                    SLVWRITE;
  logic [ADDR_W-1:0]       SLVADDR;
  logic [DATA_W-1:0]       SLVWDATA;
  logic [STRB_W-1:0]       SLVSTRB;
  logic [N_SLV*DATA_W-1:0] SLV_PRDATA;
  logic [N_SLV-1:0]        SLV_PREADY;
  logic [N_SLV-1:0]        SLV_PSLVERR;

  // The master side is the environment: bridge requests plus the peripherals' responses.
  modport master (
    output PADDR, PWDATA, PSTRB, PSEL, PENABLE, PWRITE,
    output SLV_PRDATA, SLV_PREADY, SLV_PSLVERR,
    input  PRDATA, PREADY, PSLVERR,
    input  SLV_PSEL, SLVENABLE, SLVWRITE, SLVADDR, SLVWDATA, SLVSTRB
  );

  modport slave (
    input  PADDR, PWDATA, PSTRB, PSEL, PENABLE, PWRITE,
    input  SLV_PRDATA, SLV_PREADY, SLV_PSLVERR,
    output PRDATA, PREADY, PSLVERR,
    output SLV_PSEL, SLVENABLE, SLVWRITE, SLVADDR, SLVWDATA, SLVSTRB
  );

endinterface

// File: rtl/apb_addr_dec.sv
// Combinational APB address decoder: PADDR -> {hit, slot} for a 64 KiB window split into 16 slots.
module apb_addr_dec
  import apb_mux_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned N_SLV    = 4,
  parameter int unsigned BASE_HI  = 32'(DEFAULT_BASE_HI),
  parameter int unsigned SLOT_LSB = 8
) (
  input  logic [ADDR_W-1:0] paddr_i,
  output logic              hit_o,
  output logic [SLOT_W-1:0] slot_o
);

  logic unusedAddr;

  assign slot_o = paddr_i[SLOT_LSB +: SLOT_W];

  // Slots at or above N_SLV fall inside the window but have no peripheral behind them.
  assign hit_o = (paddr_i[ADDR_W-1:16] == (ADDR_W-16)'(BASE_HI)) &&
                 ({1'b0, slot_o} < (SLOT_W+1)'(N_SLV));

  assign unusedAddr = ^{paddr_i[15:SLOT_LSB+SLOT_W], paddr_i[SLOT_LSB-1:0]};

endmodule

// File: rtl/apb_slave_mux.sv
// APB decoder / response mux between the bridge and N_SLV peripherals; unmapped or hung accesses get an error.
// Build option: define APB_MUX_TIMEOUT_EN to enable the access-phase watchdog (TIMEOUT_CYC cycles).
module apb_slave_mux
  import apb_mux_pkg::*;
#(
`ifdef APB_MUX_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 16,
`endif
  parameter int unsigned N_SLV    = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned STRB_W   = 2,
  parameter int unsigned BASE_HI  = 32'(DEFAULT_BASE_HI),
  parameter int unsigned SLOT_LSB = 8
) (
  input logic            clk,
  input logic            rst,
  apb_slave_mux_if.slave bus
);

  mux_state_e        state_q, state_d;
  logic [SLOT_W-1:0] sel_q, sel_d;
  logic              decHit;
  logic [SLOT_W-1:0] decSlot;
  logic              selRdy, selErr;
  logic [DATA_W-1:0] selData, rspData;
  logic [N_SLV-1:0]  slvPsel;
  logic              slvEnable, pready, pslverr, wdgExpired;

  apb_addr_dec #(
    .ADDR_W  (ADDR_W),
    .N_SLV   (N_SLV),
    .BASE_HI (BASE_HI),
    .SLOT_LSB(SLOT_LSB)
  ) u_dec (
    .paddr_i(bus.PADDR),
    .hit_o  (decHit),
    .slot_o (decSlot)
  );

  always_comb begin
    selRdy  = 1'b0;
    selErr  = 1'b0;
    selData = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (sel_q == SLOT_W'(i)) begin
        selRdy  = bus.SLV_PREADY[i];
        selErr  = bus.SLV_PSLVERR[i];
        selData = bus.SLV_PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_MUX_TIMEOUT_EN
  localparam int unsigned WDG_W = $clog2(TIMEOUT_CYC + 1);
  logic [WDG_W-1:0] wait_cnt_q;

  assign wdgExpired = (wait_cnt_q == WDG_W'(TIMEOUT_CYC - 1));

  // Counts unanswered access cycles; cleared whenever the transfer leaves ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == ACCESS && state_d == ACCESS && bus.PENABLE && !selRdy) begin
      if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 1'b1;
    end else if (state_d != ACCESS) begin
      wait_cnt_q <= '0;
    end
  end
`else
  assign wdgExpired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    slvPsel   = '0;
    slvEnable = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    rspData   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          if (decHit) begin
            for (int i = 0; i < int'(N_SLV); i++) slvPsel[i] = (decSlot == SLOT_W'(i));
            sel_d   = decSlot;
            state_d = ACCESS;
          end else begin
            state_d = ERR;
          end
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else begin
          for (int i = 0; i < int'(N_SLV); i++) slvPsel[i] = (sel_q == SLOT_W'(i));
          slvEnable = bus.PENABLE;
          // A slave answering in the expiry cycle takes precedence over the watchdog.
          if (bus.PENABLE && selRdy) begin
            pready  = 1'b1;
            pslverr = selErr;
            rspData = selData;
            state_d = IDLE;
          end else if (bus.PENABLE && wdgExpired) begin
            pready  = 1'b1;
            pslverr = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ERR: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (bus.PENABLE) begin
          pready  = 1'b1;
          pslverr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SLOT_UART;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.SLV_PSEL  = slvPsel;
  assign bus.SLVENABLE = slvEnable;
  assign bus.PREADY    = pready;
  assign bus.PSLVERR   = pslverr;
  assign bus.PRDATA    = (pready && !bus.PWRITE) ? rspData : '0;
  assign bus.SLVWRITE  = bus.PSEL ? bus.PWRITE : 1'b0;
  assign bus.SLVADDR   = bus.PSEL ? bus.PADDR  : '0;
  assign bus.SLVWDATA  = bus.PSEL ? bus.PWDATA : '0;
  assign bus.SLVSTRB   = bus.PSEL ? bus.PSTRB  : '0;

endmodule

// File: tb/tb_apb_slave_mux.sv
// Self-checking bench for apb_slave_mux; follows APB_MUX_TIMEOUT_EN to pick the watchdog or hang scenario.
module tb_apb_slave_mux;

  localparam int unsigned N_SLV = 4;
  localparam int unsigned TOUT  = 16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  apb_slave_mux_if #(.N_SLV(N_SLV), .DATA_W(32), .ADDR_W(32), .STRB_W(2)) bus ();

  apb_slave_mux #(.N_SLV(N_SLV), .DATA_W(32), .ADDR_W(32), .STRB_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode straight from the address map: window 0x2000xxxx, slot in bits 11:8.
  function automatic logic modelHit(input logic [31:0] addr);
    return (addr[31:16] == 16'h2000) && (int'(addr[11:8]) < int'(N_SLV));
  endfunction

  task automatic randomizeSlaves();
    bus.SLV_PRDATA  = {$urandom, $urandom, $urandom, $urandom};
    bus.SLV_PREADY  = 4'($urandom);
    bus.SLV_PSLVERR = 4'($urandom);
  endtask

  task automatic driveIdle();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0;  bus.PWDATA = '0;    bus.PSTRB = '0;
    randomizeSlaves();
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One idle bridge cycle: every mux output must be zero regardless of slave noise.
  task automatic idleCycle(input string tag);
    driveIdle();
    @(negedge clk);
    checks++;
    if ({bus.PREADY, bus.PSLVERR, bus.SLVENABLE, bus.SLVWRITE} !== 4'b0 || bus.SLV_PSEL !== 4'b0 ||
        bus.PRDATA !== 32'b0 || bus.SLVADDR !== 32'b0 || bus.SLVWDATA !== 32'b0 || bus.SLVSTRB !== 2'b0) begin
      failures++;
      $display("[TB] FAIL %s idle outputs: got rdy=%b err=%b sel=%b rdata=%h addr=%h, want all zero",
               tag, bus.PREADY, bus.PSLVERR, bus.SLV_PSEL, bus.PRDATA, bus.SLVADDR);
    end
    nextCycle();
  endtask

  // Complete APB transfer: setup then access cycles until the model says it finishes.
  task automatic doTransfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [1:0] strb, input int waits, input logic [31:0] rdata,
                            input logic err, input string tag);
    logic       hit;
    int         slot;
    logic [3:0] expSel;
    int         nAcc;
    logic       expRdy, expErr;
    logic [31:0] expData;
    hit    = modelHit(addr);
    slot   = int'(addr[11:8]);
    expSel = hit ? (4'b0001 << slot) : 4'b0000;
    nAcc   = hit ? waits + 1 : 1;

    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = addr;
    bus.PWRITE = wr; bus.PWDATA = wdata; bus.PSTRB = strb;
    randomizeSlaves();
    @(negedge clk);
    checks++;
    if (bus.SLV_PSEL !== expSel || bus.PREADY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s setup: got sel=%b rdy=%b, want sel=%b rdy=0", tag, bus.SLV_PSEL, bus.PREADY, expSel);
    end
    checks++;
    if (bus.SLVADDR !== addr || bus.SLVWDATA !== wdata || bus.SLVWRITE !== wr || bus.SLVSTRB !== strb) begin
      failures++;
      $display("[TB] FAIL %s forward: got addr=%h wdata=%h wr=%b strb=%b, want %h %h %b %b",
               tag, bus.SLVADDR, bus.SLVWDATA, bus.SLVWRITE, bus.SLVSTRB, addr, wdata, wr, strb);
    end
    nextCycle();

    bus.PENABLE = 1'b1;
    for (int k = 0; k < nAcc; k++) begin
      randomizeSlaves();
      if (hit) begin
        bus.SLV_PREADY[slot]               = (k == waits);
        bus.SLV_PSLVERR[slot]              = err;
        bus.SLV_PRDATA[slot*32 +: 32]      = rdata;
      end
      @(negedge clk);
      expRdy  = (k == nAcc - 1);
      expErr  = expRdy && (hit ? err : 1'b1);
      expData = (expRdy && hit && !wr) ? rdata : 32'h0;
      checks++;
      if (bus.PREADY !== expRdy || bus.PSLVERR !== expErr || bus.PRDATA !== expData) begin
        failures++;
        $display("[TB] FAIL %s access%0d: got rdy=%b err=%b rdata=%h, want rdy=%b err=%b rdata=%h",
                 tag, k, bus.PREADY, bus.PSLVERR, bus.PRDATA, expRdy, expErr, expData);
      end
      checks++;
      if (bus.SLV_PSEL !== expSel || (hit && bus.SLVENABLE !== 1'b1) || bus.SLVWDATA !== wdata) begin
        failures++;
        $display("[TB] FAIL %s access%0d select: got sel=%b en=%b wdata=%h, want sel=%b wdata=%h",
                 tag, k, bus.SLV_PSEL, bus.SLVENABLE, bus.SLVWDATA, expSel, wdata);
      end
      nextCycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    driveIdle();
    nextCycle();
    nextCycle();
    @(negedge clk);
    checks++;
    if (bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0 || bus.SLV_PSEL !== 4'b0 || bus.PRDATA !== 32'b0) begin
      failures++;
      $display("[TB] FAIL reset outputs: got rdy=%b err=%b sel=%b rdata=%h, want zero",
               bus.PREADY, bus.PSLVERR, bus.SLV_PSEL, bus.PRDATA);
    end
    nextCycle();
    rst = 1'b0;
    idleCycle("post_reset");
  endtask

  task automatic test_directed();
    doTransfer(32'h2000_0004, 1'b0, 32'h0, 2'b00, 0, 32'hA5A5_0001, 1'b0, "read_slot0");
    idleCycle("after_read_slot0");
    doTransfer(32'h2000_0208, 1'b1, 32'h0000_1234, 2'b11, 3, 32'hDEAD_BEEF, 1'b0, "write_slot2");
    idleCycle("after_write_slot2");
    doTransfer(32'h2000_0310, 1'b0, 32'h0, 2'b00, 1, 32'h0BAD_0003, 1'b1, "slave_err_slot3");
    idleCycle("after_slave_err");
  endtask

  task automatic test_unmapped();
    doTransfer(32'h3000_0000, 1'b0, 32'h0, 2'b00, 0, 32'h0, 1'b0, "unmapped_base");
    idleCycle("after_unmapped_base");
    doTransfer(32'h2000_0500, 1'b0, 32'h0, 2'b00, 0, 32'h0, 1'b0, "unmapped_slot");
    idleCycle("after_unmapped_slot");
  endtask

  task automatic test_back_to_back();
    doTransfer(32'h2000_0000, 1'b0, 32'h0, 2'b00, 0, 32'h1111_0000, 1'b0, "b2b_read_slot0");
    doTransfer(32'h2000_0104, 1'b1, 32'h0000_5678, 2'b01, 0, 32'h0, 1'b0, "b2b_write_slot1");
    doTransfer(32'h2000_0700, 1'b0, 32'h0, 2'b00, 0, 32'h0, 1'b0, "b2b_unmapped");
    doTransfer(32'h2000_0300, 1'b0, 32'h0, 2'b00, 2, 32'h3333_0033, 1'b0, "b2b_read_slot3");
    idleCycle("after_b2b");
  endtask

  task automatic test_reset_mid();
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'h2000_0300;
    bus.SLV_PREADY = 4'b0000;
    nextCycle();
    bus.PENABLE = 1'b1;
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.PREADY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid during: got rdy=%b, want 0", bus.PREADY);
    end
    nextCycle();
    rst = 1'b0;
    bus.SLV_PREADY = 4'b1111;
    bus.SLV_PRDATA = {4{32'hCAFE_F00D}};
    @(negedge clk);
    checks++;
    if (bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0 || bus.SLV_PSEL !== 4'b0 ||
        bus.SLVENABLE !== 1'b0 || bus.PRDATA !== 32'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid abandoned: got rdy=%b err=%b sel=%b en=%b rdata=%h, want zero",
               bus.PREADY, bus.PSLVERR, bus.SLV_PSEL, bus.SLVENABLE, bus.PRDATA);
    end
    nextCycle();
    idleCycle("reset_mid_idle");
    doTransfer(32'h2000_0300, 1'b0, 32'h0, 2'b00, 1, 32'h3030_3030, 1'b0, "reset_mid_recover");
    idleCycle("after_reset_mid");
  endtask

`ifdef APB_MUX_TIMEOUT_EN
  task automatic test_timeout();
    logic expRdy;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'h2000_0100;
    randomizeSlaves();
    nextCycle();
    bus.PENABLE = 1'b1;
    for (int k = 1; k <= int'(TOUT); k++) begin
      randomizeSlaves();
      bus.SLV_PREADY[1] = 1'b0;
      bus.SLV_PRDATA[32 +: 32] = 32'hFFFF_FFFF;
      @(negedge clk);
      expRdy = (k == int'(TOUT));
      checks++;
      if (bus.PREADY !== expRdy || bus.PSLVERR !== expRdy || bus.PRDATA !== 32'h0 || bus.SLV_PSEL !== 4'b0010) begin
        failures++;
        $display("[TB] FAIL timeout access%0d: got rdy=%b err=%b rdata=%h sel=%b, want rdy=%b err=%b rdata=0 sel=0010",
                 k, bus.PREADY, bus.PSLVERR, bus.PRDATA, bus.SLV_PSEL, expRdy, expRdy);
      end
      nextCycle();
    end
    doTransfer(32'h2000_0000, 1'b0, 32'h0, 2'b00, 0, 32'h0000_AAAA, 1'b0, "after_timeout_slot0");
    idleCycle("after_timeout");
    doTransfer(32'h2000_0200, 1'b0, 32'h0, 2'b00, int'(TOUT) - 1, 32'h5A5A_5A5A, 1'b0, "ready_at_expiry");
    idleCycle("after_ready_at_expiry");
  endtask
`else
  task automatic test_long_wait();
    doTransfer(32'h2000_0100, 1'b0, 32'h0, 2'b00, 24, 32'h7777_0001, 1'b0, "long_wait_slot1");
    idleCycle("after_long_wait");
  endtask
`endif

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 30; n++) begin
      addr = {(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h2000),
              4'($urandom), 4'($urandom_range(0, 5)), 8'($urandom)};
      doTransfer(addr, 1'($urandom), $urandom, 2'($urandom), $urandom_range(0, 4),
                 $urandom, ($urandom_range(0, 3) == 0), $sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) idleCycle($sformatf("rand%0d_idle", n));
    end
    idleCycle("after_random");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    driveIdle();
    test_reset();
    test_directed();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_MUX_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_slave_mux.md
# apb_slave_mux

Parametrised APB decoder and response multiplexer sitting between the APB bridge and N peripheral slaves (UART at slot 0, further peripherals at higher slots). It decodes the bridge address window into one-hot slave selects and tracks each transfer with a small state machine. It returns the selected slave's PRDATA/PREADY/PSLVERR to the bridge. It also answers unmapped addresses and hung slaves with a one-cycle error response, so the bridge never stalls.

## Interface
- N_SLV, 4, number of slave ports (1..16)
- DATA_W, 32, data width
- ADDR_W, 32, address width
- STRB_W, 2, write-strobe width
- BASE_HI, 16'h2000, required value of PADDR[ADDR_W-1:16]
- SLOT_LSB, 8, lowest slot-index bit; slot = PADDR[SLOT_LSB+3:SLOT_LSB]
- TIMEOUT_CYC, 16, max access-phase wait cycles before error (watchdog build only)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- PADDR  in  ADDR_W  bridge address
- PWDATA  in  DATA_W  bridge write data
- PSTRB  in  STRB_W  bridge strobes
- PSEL, PENABLE, PWRITE  in  1 each  bridge APB control
- PRDATA  out  DATA_W  read data to bridge
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- SLV_PSEL  out  N_SLV  one-hot slave select
- SLVENABLE, SLVWRITE  out  1 each  forwarded PENABLE/PWRITE
- SLVADDR  out  ADDR_W  forwarded PADDR
- SLVWDATA  out  DATA_W  forwarded PWDATA
- SLVSTRB  out  STRB_W  forwarded PSTRB
- SLV_PRDATA  in  N_SLV*DATA_W  slave i read data at [i*DATA_W +: DATA_W]
- SLV_PREADY, SLV_PSLVERR  in  N_SLV each  per-slave ready/error

## Operation
- Hit: PADDR[ADDR_W-1:16]==BASE_HI and slot < N_SLV. Anything else is unmapped.
- FSM states: IDLE, ACCESS, ERR. Registered: state, sel_q (slot index), wait_cnt.
- IDLE, PSEL & !PENABLE (setup):
  - On hit: SLV_PSEL[slot]=1 combinationally, sel_q<=slot, next state ACCESS.
  - On miss: SLV_PSEL=0, next state ERR.
- IDLE, any other input: no slave selected, outputs zero.
- ACCESS:
  - SLV_PSEL[sel_q]=PSEL and SLVENABLE=PENABLE.
  - PREADY, PSLVERR, and PRDATA are taken from slave sel_q.
  - When PENABLE & SLV_PREADY[sel_q]: next state IDLE, wait_cnt<=0.
- ERR: when PENABLE, drive PREADY=1, PSLVERR=1, PRDATA=0, then go to IDLE.
- PSEL dropped in ACCESS/ERR (protocol violation): go to IDLE, no response.
- SLVADDR/SLVWDATA/SLVSTRB/SLVWRITE equal the bridge inputs while PSEL=1, else 0.
- Slave responses are ignored when that slave is not selected.
- PRDATA=0 whenever PREADY=0 or PWRITE=1.

## Timing
- Reset values: state=IDLE, sel_q=0, wait_cnt=0; all outputs 0.
- Reset asserted mid-transfer: the next edge forces IDLE, PREADY stays 0, and the transfer is abandoned.
- Mapped transfer latency equals the slave latency; the mux adds no wait states. Zero-wait slave completes: setup cycle + one access cycle.
- Unmapped transfer always completes in the first access cycle with error.
- Back-to-back transfers: the completing cycle returns to IDLE, so the next setup cycle is decoded directly.
- wait_cnt increments each ACCESS cycle with PENABLE & !SLV_PREADY[sel_q]; it saturates and never wraps.
- Completion and timeout in the same cycle: the slave response wins (PSLVERR = slave's value).

## Configuration
- APB_MUX_TIMEOUT_EN defined:
  - In ACCESS, when wait_cnt==TIMEOUT_CYC-1 and the slave is still not ready, drive PREADY=1, PSLVERR=1, PRDATA=0.
  - SLV_PSEL drops and the FSM goes to IDLE on the next edge.
- APB_MUX_TIMEOUT_EN undefined: wait_cnt is not instantiated and the mux waits indefinitely on the slave.

## Structure
- Package apb_mux_pkg holds the state encoding (IDLE=2'd0, ACCESS=2'd1, ERR=2'd2), the default BASE_HI, and slot constants (SLOT_UART=0).
- One sub-module, apb_addr_dec: purely combinational PADDR -> {hit, slot}. It is reused by future bridges.
- FSM, watchdog, and response mux live in the top module.

## Test plan
- Read slot 0, PADDR=0x2000_0004, SLV_PRDATA[0]=0xA5A5_0001, zero wait -> SLV_PSEL=4'b0001 in the setup cycle; PREADY=1, PRDATA=0xA5A5_0001, PSLVERR=0 in the access cycle.
- Write slot 2, PADDR=0x2000_0208, PWDATA=0x1234, PSTRB=2'b11, slave ready after 3 waits -> SLVWDATA=0x1234, SLV_PSEL=4'b0100 for all 5 cycles, PREADY=1 only in the last cycle.
- Unmapped accesses: PADDR=0x3000_0000, then PADDR=0x2000_0500 with N_SLV=4 -> each gets PREADY=1, PSLVERR=1, PRDATA=0 in the first access cycle; SLV_PSEL stays 0.
- Timeout build, TIMEOUT_CYC=16, slave 1 never ready -> PREADY=PSLVERR=1 in the 16th access cycle; the next setup to slot 0 completes normally.
- rst pulsed during the 2nd wait cycle of a slot-3 read -> the next cycle shows all outputs 0 and state IDLE; a subsequent read completes correctly.
- Back-to-back: read slot 0, then write slot 1 with no idle cycle -> each completes, and SLV_PSEL switches from 0001 to 0010 in the second setup cycle.
